reg_bank_rr: RTL

Parametrised successor to the two-source alternating write register. NSRC write sources are selected in round-robin order, skipping masked-off sources, and written into a circular bank of DEPTH registers. Entries are read back by address through a registered read port. The block sits between multiple producer datapaths and a single consumer that samples stored words by index.

---
 rtl/reg_bank_rr.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reg_bank_rr.sv
// -----------------------------------------------------------------------------
// reg_bank_rr
//
// Circular bank of DEPTH = 2**ADDR_W registers filled from NSRC write sources.
// On each accepted write the source is chosen round-robin, starting from the
// source after the one used last and skipping sources whose mask bit is 0.
// Stored words are read back by address through a registered read port.
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset, highest priority
//   wr_en     in   write request for this cycle
//   data_in   in   NSRC packed words, source k at [k*WIDTH +: WIDTH]
//   src_mask  in   1 = source k may be selected this cycle
//   rd_en     in   read request
//   rd_addr   in   read address
//   read      out  registered read data, holds when rd_en is low
//   rd_valid  out  1-cycle pulse, the word read was written since reset
//   wr_src    out  source index used by the last accepted write
//   wr_ptr    out  address the next write goes to
//   wr_count  out  number of written entries, saturating at DEPTH
//   full      out  wr_count == DEPTH
//   err       out  1-cycle pulse, wr_en seen with an all-zero src_mask
// -----------------------------------------------------------------------------
module reg_bank_rr #(
    parameter int WIDTH  = 16,
    parameter int NSRC   = 2,
    parameter int ADDR_W = 2,
    parameter int SRC_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [NSRC*WIDTH-1:0]   data_in,
    input  logic [NSRC-1:0]         src_mask,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [WIDTH-1:0]        read,
    output logic                    rd_valid,
    output logic [SRC_W-1:0]        wr_src,
    output logic [ADDR_W-1:0]       wr_ptr,
    output logic [ADDR_W:0]         wr_count,
    output logic                    full,
    output logic                    err
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Storage and control state
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [WIDTH-1:0]  r_read;
    logic              r_rd_valid;
    logic [SRC_W-1:0]  r_wr_src;
    logic [SRC_W-1:0]  r_track;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_wr_count;
    logic              r_err;

    // Combinational source selection
    logic              w_any;
    logic              w_found;
    logic [SRC_W-1:0]  w_sel;
    int                w_idx;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_wr_ok;

    assign w_any   = |src_mask;
    assign w_wr_ok = wr_en && w_any;

    // Walk the sources starting at r_track, wrapping mod NSRC; the first
    // enabled one wins. w_found only guards against later matches.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 0; k < NSRC; k++) begin
            w_idx = int'(r_track) + k;
            if (w_idx >= NSRC) begin
                w_idx = w_idx - NSRC;
            end
            if (!w_found && src_mask[w_idx]) begin
                w_found = 1'b1;
                w_sel   = SRC_W'(w_idx);
            end
        end
    end

    assign w_wdata = data_in[int'(w_sel)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid    <= '0;
            r_read     <= '0;
            r_rd_valid <= 1'b0;
            r_wr_src   <= '0;
            r_track    <= '0;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= wr_en && !w_any;

            // Read samples the bank before this cycle's write lands, so a
            // read of r_wr_ptr returns the old word and old valid bit.
            if (rd_en) begin
                r_read     <= r_mem[rd_addr];
                r_rd_valid <= r_valid[rd_addr];
            end else begin
                r_rd_valid <= 1'b0;
            end

            if (w_wr_ok) begin
                r_mem[r_wr_ptr]   <= w_wdata;
                r_valid[r_wr_ptr] <= 1'b1;
                // DEPTH is a power of two, so the pointer wraps naturally.
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_wr_src          <= w_sel;
                if (int'(w_sel) == NSRC - 1) begin
                    r_track <= '0;
                end else begin
                    r_track <= w_sel + 1'b1;
                end
                // Once full, writes overwrite the oldest entry and the
                // count stays saturated.
                if (r_wr_count != DEPTH_C) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
            end
        end
    end

    assign read     = r_read;
    assign rd_valid = r_rd_valid;
    assign wr_src   = r_wr_src;
    assign wr_ptr   = r_wr_ptr;
    assign wr_count = r_wr_count;
    assign full     = (r_wr_count == DEPTH_C);
    assign err      = r_err;

endmodule
